// File: rtl/lcd_send_word_if.sv
// Request-side bus of lcd_send_word: the request/acknowledge handshake, the
// per-transaction attributes and the returned read byte.
//
// Handshake: the requester raises rq_i to start one transaction.
// - Only a rising edge of rq_i counts, and only while busy_o is low.
// - The attributes rqRs_i, rqRw_i, rqHalf_i, rqData_i and rqDel_i are captured
//   on that same edge.
// - busy_o stays high until the transaction is finished.
// - ack_o pulses high for one cycle at the end of the transaction; rdData_o is
//   valid in that cycle.
// - Before the next request, rq_i has to return low and then rise again.
//
// Modports:
//   master : the sequencer side (drives the request)
//   slave  : lcd_send_word (drives ack_o, busy_o and rdData_o)
interface lcd_send_word_if #(
    parameter int DEL_W = 18
) ();
    logic             rq_i;
    logic             ack_o;
    logic             busy_o;
    logic             rqRs_i;
    logic             rqRw_i;
    logic             rqHalf_i;
    logic [7:0]       rqData_i;
    logic [DEL_W-1:0] rqDel_i;
    logic [7:0]       rdData_o;

    modport master (
        output rq_i, rqRs_i, rqRw_i, rqHalf_i, rqData_i, rqDel_i,
        input  ack_o, busy_o, rdData_o
    );

    modport slave (
        input  rq_i, rqRs_i, rqRw_i, rqHalf_i, rqData_i, rqDel_i,
        output ack_o, busy_o, rdData_o
    );
endinterface

// File: rtl/lcd_send_word.sv
// lcd_send_word: runs one HD44780-style bus transaction per request.
// - The transaction is a write or a read, on a 4-bit or 8-bit bus.
// - Each nibble/byte phase is SETUP (E low), PULSE (E high) and HOLD (E low).
// - After the last phase the bus returns to 0.
// - An optional idle delay follows, then a one-cycle acknowledge.
//
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   req             : request bus (slave modport of lcd_send_word_if)
//   lcdE_o, lcdRs_o, lcdRw_o, lcdData_o, lcdDataOe_o : LCD pins (registered)
//   lcdData_i       : LCD data in, used by reads
//   dbg_state_o     : current FSM state, for observation only
module lcd_send_word #(
    parameter int BUS_W     = 4,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 1,
    parameter int DEL_W     = 18
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    lcd_send_word_if.slave    req,
    output logic              lcdE_o,
    output logic              lcdRs_o,
    output logic              lcdRw_o,
    output logic [BUS_W-1:0]  lcdData_o,
    output logic              lcdDataOe_o,
    input  logic [BUS_W-1:0]  lcdData_i,
    output logic [2:0]        dbg_state_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DELAY = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    localparam int  MAXC   = (SETUP_CYC > PULSE_CYC)
                             ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                             : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int  CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam bit  TWO_PH = (BUS_W == 4);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;     // cycles left in the current phase step
    logic [DEL_W-1:0] del_q, del_d;     // captured delay, counted down in DELAY
    logic             rq_q;
    logic             rs_q, rs_d, rw_q, rw_d, half_q, half_d, ph2_q, ph2_d;
    logic [7:0]       byte_q, byte_d, rdbuf_q, rdbuf_d, rd_q, rd_d;

    logic             e_q, rso_q, rwo_q, oe_q, ack_q, busy_q;
    logic [BUS_W-1:0] dat_q;

    logic             start, in_ph;
    logic [BUS_W-1:0] bus_d;            // bus value for the phase being entered
    logic [7:0]       rdbuf_smp;        // read buffer with this phase's sample merged

    assign start = (state_q == S_IDLE) && req.rq_i && !rq_q;

    generate
        if (TWO_PH) begin : g_nib
            assign bus_d     = ph2_d ? byte_d[3:0] : byte_d[7:4];
            assign rdbuf_smp = ph2_q ? {rdbuf_q[7:4], lcdData_i} : {lcdData_i, 4'h0};
        end else begin : g_byte
            assign bus_d     = byte_d;
            assign rdbuf_smp = lcdData_i;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        del_d   = del_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        half_d  = half_q;
        ph2_d   = ph2_q;
        byte_d  = byte_q;
        rdbuf_d = rdbuf_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    rs_d    = req.rqRs_i;
                    rw_d    = req.rqRw_i;
                    half_d  = req.rqHalf_i;
                    byte_d  = req.rqData_i;
                    del_d   = req.rqDel_i;
                    ph2_d   = 1'b0;
                    rdbuf_d = 8'h00;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    if (rw_q) rdbuf_d = rdbuf_smp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (TWO_PH && !half_q && !ph2_q) begin
                    // Low nibble follows directly; RS/RW stay asserted.
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    ph2_d   = 1'b1;
                end else if (del_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (del_q == DEL_W'(1)) state_d = S_ACK;
                else                    del_d   = del_q - DEL_W'(1);
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Publish the read byte together with the acknowledge.
        if (state_d == S_ACK && state_q != S_ACK && rw_q) rd_d = rdbuf_q;
    end

    // Outputs are registered from the next state so pins line up with state_q.
    assign in_ph = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            del_q   <= '0;
            rq_q    <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            half_q  <= 1'b0;
            ph2_q   <= 1'b0;
            byte_q  <= 8'h00;
            rdbuf_q <= 8'h00;
            rd_q    <= 8'h00;
            e_q     <= 1'b0;
            rso_q   <= 1'b0;
            rwo_q   <= 1'b0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            del_q   <= del_d;
            rq_q    <= req.rq_i;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            half_q  <= half_d;
            ph2_q   <= ph2_d;
            byte_q  <= byte_d;
            rdbuf_q <= rdbuf_d;
            rd_q    <= rd_d;
            e_q     <= (state_d == S_PULSE);
            rso_q   <= in_ph & rs_d;
            rwo_q   <= in_ph & rw_d;
            oe_q    <= in_ph & ~rw_d;
            ack_q   <= (state_d == S_ACK);
            busy_q  <= (state_d != S_IDLE);
            dat_q   <= (in_ph && !rw_d) ? bus_d : '0;
        end
    end

    assign lcdE_o       = e_q;
    assign lcdRs_o      = rso_q;
    assign lcdRw_o      = rwo_q;
    assign lcdData_o    = dat_q;
    assign lcdDataOe_o  = oe_q;
    assign req.ack_o    = ack_q;
    assign req.busy_o   = busy_q;
    assign req.rdData_o = rd_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_lcd_send_word.sv
module tb_lcd_send_word;
  localparam int DEL_A = 18;
  localparam int DEL_B = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared stimulus ----------------
  logic        sel;            // 0: 4-bit default instance, 1: 8-bit fast instance
  logic        rq, rs, rw, half;
  logic [7:0]  data;
  logic [17:0] del;
  logic [7:0]  lcd_in;

  lcd_send_word_if #(.DEL_W(DEL_A)) a_if ();
  lcd_send_word_if #(.DEL_W(DEL_B)) b_if ();

  assign a_if.rq_i     = rq & ~sel;
  assign a_if.rqRs_i   = rs;
  assign a_if.rqRw_i   = rw;
  assign a_if.rqHalf_i = half;
  assign a_if.rqData_i = data;
  assign a_if.rqDel_i  = del;
  assign b_if.rq_i     = rq & sel;
  assign b_if.rqRs_i   = rs;
  assign b_if.rqRw_i   = rw;
  assign b_if.rqHalf_i = half;
  assign b_if.rqData_i = data;
  assign b_if.rqDel_i  = del[DEL_B-1:0];

  logic       a_e, a_rs, a_rw, a_oe;
  logic [3:0] a_data;
  logic [2:0] a_dbg;
  logic       b_e, b_rs, b_rw, b_oe;
  logic [7:0] b_data;
  logic [2:0] b_dbg;

  lcd_send_word #(.BUS_W(4)) u_a (
    .clk_i(clk), .reset_ni(rst_n), .req(a_if),
    .lcdE_o(a_e), .lcdRs_o(a_rs), .lcdRw_o(a_rw), .lcdData_o(a_data),
    .lcdDataOe_o(a_oe), .lcdData_i(lcd_in[3:0]), .dbg_state_o(a_dbg)
  );

  lcd_send_word #(.BUS_W(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .DEL_W(DEL_B)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .req(b_if),
    .lcdE_o(b_e), .lcdRs_o(b_rs), .lcdRw_o(b_rw), .lcdData_o(b_data),
    .lcdDataOe_o(b_oe), .lcdData_i(lcd_in), .dbg_state_o(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {e, rs, rw, oe, ack, busy, data[7:0], rd[7:0]}
  function automatic logic [21:0] obs();
    if (sel) return {b_e, b_rs, b_rw, b_oe, b_if.ack_o, b_if.busy_o, b_data, b_if.rdData_o};
    else     return {a_e, a_rs, a_rw, a_oe, a_if.ack_o, a_if.busy_o, 4'h0, a_data, a_if.rdData_o};
  endfunction

  // Reference: expected pins in cycle j after the accepting edge, from the
  // phase arithmetic (T cycles per phase, N phases, del idle, then ack).
  function automatic logic [21:0] model(input bit s, input bit m_rs, input bit m_rw,
                                        input bit m_half, input logic [7:0] m_byte,
                                        input int m_del, input int j,
                                        input logic [7:0] old_rd, input logic [7:0] new_rd);
    int sc, pc, t, n, l, o, p;
    logic e, r_s, r_w, oe, ack, busy;
    logic [7:0] d, rd;
    sc = s ? 1 : 2;
    pc = s ? 1 : 12;
    t  = sc + pc + 1;
    n  = (s || m_half) ? 1 : 2;
    l  = n * t;
    e = 0; r_s = 0; r_w = 0; oe = 0; ack = 0; busy = 0; d = 8'h00;
    if (j < l) begin
      o = j % t;
      p = j / t;
      e = (o >= sc) && (o < sc + pc);
      r_s = m_rs; r_w = m_rw; oe = !m_rw; busy = 1;
      if (!m_rw) d = s ? m_byte : (p == 0 ? {4'h0, m_byte[7:4]} : {4'h0, m_byte[3:0]});
    end else if (j < l + m_del) begin
      busy = 1;
    end else if (j == l + m_del) begin
      ack = 1; busy = 1;
    end
    rd = (j >= l + m_del && m_rw) ? new_rd : old_rd;
    return {e, r_s, r_w, oe, ack, busy, d, rd};
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input bit s, input bit t_rs, input bit t_rw, input bit t_half,
                         input logic [7:0] t_byte, input int t_del,
                         input logic [7:0] ph0, input logic [7:0] ph1,
                         input bit poke, input bit at_negedge);
    int t, l;
    logic [7:0] new_rd, rd_exp;
    logic [21:0] e_vec;
    if (!at_negedge) @(negedge clk);
    sel = s; rs = t_rs; rw = t_rw; half = t_half; data = t_byte; del = 18'(t_del);
    rq = 1'b1;
    t = s ? 3 : 15;
    l = ((s || t_half) ? 1 : 2) * t;
    if (s)           new_rd = ph0;
    else if (t_half) new_rd = {ph0[3:0], 4'h0};
    else             new_rd = {ph0[3:0], ph1[3:0]};
    if (t_rw) exp_q.push_back(new_rd);
    @(posedge clk); #1;
    // Attributes were captured at the accepting edge; later changes must not matter.
    rs = 1'($urandom); rw = 1'($urandom); half = 1'($urandom);
    data = 8'($urandom); del = 18'($urandom);
    for (int j = 0; j <= l + t_del + 2; j++) begin
      lcd_in = (j < l) ? ((j / t == 0) ? ph0 : ph1) : 8'($urandom);
      if (poke && j == 5) rq = 1'b0;
      if (poke && j == 6) rq = 1'b1;
      @(negedge clk);
      e_vec = model(s, t_rs, t_rw, t_half, t_byte, t_del, j, last_rd[s], new_rd);
      check($sformatf("outs s=%0d j=%0d", s, j), 32'(obs()), 32'(e_vec));
      if (j == l + t_del && t_rw) begin
        if (exp_q.size() == 0) begin
          check("rd_q_underflow", 32'(1), 32'(0));
        end else begin
          rd_exp = exp_q.pop_front();
          check("rd_ack", 32'(obs() & 22'hff), 32'(rd_exp));
        end
      end
      @(posedge clk); #1;
    end
    if (t_rw) last_rd[s] = new_rd;
    rq = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b0; rq = 1'b0; sel = 1'b0; rs = 1'b0; rw = 1'b0; half = 1'b0;
    data = 8'h00; del = 18'h0; lcd_in = 8'h00;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    #12;
    check("reset_a", 32'(obs()), 32'(0));
    sel = 1'b1;
    #1;
    check("reset_b", 32'(obs()), 32'(0));
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);

    // directed: write A5 in two nibbles, half write with delay, full read, half read
    run_txn(0, 1, 0, 0, 8'hA5, 0, 8'h00, 8'h00, 0, 0);
    run_txn(0, 1, 0, 1, 8'h30, 5, 8'h00, 8'h00, 0, 0);
    run_txn(0, 0, 1, 0, 8'h00, 0, 8'h08, 8'h00, 0, 0);
    run_txn(0, 1, 1, 1, 8'h00, 3, 8'h0C, 8'h07, 0, 0);
    // write after read leaves rdData_o alone; mid-transaction re-request dropped
    run_txn(0, 0, 0, 0, 8'h3C, 2, 8'h00, 8'h00, 1, 0);

    // reset while E is high aborts at once; rq still high starts on first clock
    @(negedge clk);
    sel = 1'b0; rs = 1'b1; rw = 1'b0; half = 1'b0; data = 8'h5A; del = 18'h0; rq = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_e", 32'(a_e), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs()), 32'(0));
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    run_txn(0, 1, 0, 0, 8'h96, 1, 8'h00, 8'h00, 0, 1);

    // 8-bit instance: shortest phases, full-width delay, then a read
    run_txn(1, 1, 0, 0, 8'hC3, (1 << DEL_B) - 1, 8'h00, 8'h00, 0, 0);
    run_txn(1, 0, 1, 1, 8'h00, 0, 8'h9E, 8'h00, 0, 0);

    // randomized traffic on both instances
    for (int i = 0; i < 24; i++) begin
      run_txn(1'(i % 2), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
              int'($urandom_range(0, 20)), 8'($urandom), 8'($urandom),
              (i % 2 == 0) && ($urandom_range(0, 3) == 0), 0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
